// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Checksum support is enabled with the IMEM_LOADER_CHECKSUM_EN macro.
package imem_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = 32;
   localparam int LANE_W         = $clog2(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      LEN,
      DATA,
      CHK,
      FIN,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The master modport is the loader side; slave is the source/RAM side.
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8
);

   logic [7:0]        s_data;
   logic              s_valid;
   logic              s_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [WORD_W-1:0] imem_wdata;

   modport master (
      input  s_data, s_valid,
      output s_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output s_data, s_valid,
      input  s_ready, imem_we, imem_addr, imem_wdata
   );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid pulses the
// cycle after the fourth lane is accepted, with the word held on 'word'.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              last_lane,
   output logic              word_valid,
   output logic [WORD_W-1:0] word
);

   logic [LANE_W-1:0] lane;
   logic [WORD_W-9:0] partial;

   assign last_lane = byte_valid && (lane == LANE_W'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         lane       <= '0;
         partial    <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= last_lane;
         if (byte_valid) begin
            lane <= lane + 1'b1;
            case (lane)
               2'd0:    partial[7:0]   <= byte_data;
               2'd1:    partial[15:8]  <= byte_data;
               2'd2:    partial[23:16] <= byte_data;
               default: ;
            endcase
         end
      end
   end

   // The top byte never lands in 'partial'; it goes straight into the output word.
   always_ff @(posedge clk) begin
      if (reset) begin
         word <= '0;
      end else if (last_lane) begin
         word <= {byte_data, partial};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the
// CPU in reset until done. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8
)(
   input  logic          clk,
   input  logic          reset,
   imem_loader_if.master bus,
   input  logic          load_req,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);

   state_t            state;
   state_t            next_state;
   logic              accept;
   logic              restart;
   logic              data_byte;
   logic              last_lane;
   logic              word_valid;
   logic [WORD_W-1:0] word;
   logic [7:0]        words_left;
   logic [ADDR_W-1:0] word_idx;
   logic [ADDR_W-1:0] addr_q;

   assign accept    = bus.s_valid && bus.s_ready;
   assign restart   = load_req && ((state == DONE) || (state == ERR));
   assign data_byte = accept && (state == DATA);

   imem_loader_byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (restart),
      .byte_valid (data_byte),
      .byte_data  (bus.s_data),
      .last_lane  (last_lane),
      .word_valid (word_valid),
      .word       (word)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t AFTER_DATA = CHK;
   logic [7:0] chk;
   logic       chk_ok;

   // LEN starts from a zero register, so XOR-ing it in is the same as loading it.
   always_ff @(posedge clk) begin
      if (reset || restart) begin
         chk <= '0;
      end else if (accept && ((state == LEN) || (state == DATA))) begin
         chk <= chk ^ bus.s_data;
      end
   end

   assign chk_ok = (chk == bus.s_data);
`else
   localparam state_t AFTER_DATA = FIN;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LEN;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         LEN:  if (accept) next_state = (bus.s_data == 8'd0) ? AFTER_DATA : DATA;
         DATA: if (last_lane && (words_left == 8'd1)) next_state = AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK:  if (accept) next_state = chk_ok ? FIN : ERR;
`else
         CHK:  next_state = LEN;
`endif
         FIN:  next_state = DONE;
         DONE: if (load_req) next_state = LEN;
         ERR:  if (load_req) next_state = LEN;
         default: next_state = LEN;
      endcase
   end

   // Word index wraps naturally at the memory depth.
   always_ff @(posedge clk) begin
      if (reset || restart) begin
         words_left <= '0;
         word_idx   <= '0;
      end else begin
         if (accept && (state == LEN)) begin
            words_left <= bus.s_data;
         end
         if (last_lane) begin
            words_left <= words_left - 8'd1;
            word_idx   <= word_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
      end else if (last_lane) begin
         addr_q <= word_idx;
      end
   end

   assign bus.imem_we    = word_valid;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = word;

   // s_ready is masked by reset so the stream sees no acceptance while reset is held.
   always_comb begin
      bus.s_ready = 1'b0;
      cpu_hold    = 1'b1;
      done        = 1'b0;
      err         = 1'b0;
      case (state)
         LEN, DATA, CHK: bus.s_ready = !reset;
         DONE: begin
            cpu_hold = 1'b0;
            done     = 1'b1;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ERR:  err = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frames plus hand-written
// reset, load_req and checksum sequences; writes are scoreboarded in a queue.
module tb_imem_loader;

   localparam int AW = 8;

   logic clk = 1'b0;
   logic reset;
   logic load_req;
   logic cpu_hold;
   logic done;
   logic err;

   imem_loader_if #(.ADDR_W(AW)) bus ();

   imem_loader #(.ADDR_W(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .load_req (load_req),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   typedef struct {
      int               n;
      logic [3:0][31:0] words;
      bit               gaps;
   } vec_t;

   wr_t exp_q[$];
   int  total = 0;
   int  bad = 0;
   int  cycle = 0;
   int  last_we_cycle = -1;
   int  done_cycle = -1;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      wr_t e;
      if (reset === 1'b0 && bus.imem_we === 1'b1) begin
         last_we_cycle = cycle;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%08h, expected no write",
                     bus.imem_addr, bus.imem_wdata);
         end else begin
            e = exp_q.pop_front();
            check_output("write_addr", 32'(bus.imem_addr), 32'(e.addr));
            check_output("write_data", bus.imem_wdata, e.data);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int waited;
      waited = 0;
      @(negedge clk);
      bus.s_data  = b;
      bus.s_valid = 1'b1;
      while (bus.s_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (bus.s_ready !== 1'b1) begin
         total++;
         bad++;
         $display("[TB] FAIL send_timeout: got s_ready=%b, expected 1", bus.s_ready);
      end
      @(posedge clk);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      bus.s_valid = 1'b0;
      @(posedge clk);
   endtask

   task automatic end_stream();
      @(negedge clk);
      bus.s_valid = 1'b0;
   endtask

   task automatic push_write(input int idx, input logic [31:0] data);
      wr_t e;
      e.addr = AW'(idx);
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic send_frame(input int n, input logic [3:0][31:0] words, input bit gaps,
                             input logic [7:0] chk_xor);
      logic [7:0] chk;
      logic [7:0] b;
      chk = n[7:0];
      send_byte(n[7:0]);
      for (int i = 0; i < n; i++) begin
         push_write(i, words[i]);
         for (int k = 0; k < 4; k++) begin
            if (gaps) idle_cycle();
            b = words[i][8*k +: 8];
            chk = chk ^ b;
            send_byte(b);
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(chk ^ chk_xor);
`else
      if (chk_xor != 8'd0) send_byte(chk);
`endif
      end_stream();
   endtask

   task automatic wait_finish(input string name);
      int k;
      k = 0;
      while (done !== 1'b1 && err !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      done_cycle = cycle;
      check_output({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      if (k >= 200) begin
         total++;
         bad++;
         $display("[TB] FAIL %s_timeout: got done=%b err=%b, expected completion", name, done, err);
      end
   endtask

   task automatic check_done(input string name);
      wait_finish(name);
      check_output({name, "_done"}, 32'(done), 32'd1);
      check_output({name, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
      check_output({name, "_err"}, 32'(err), 32'd0);
      check_output({name, "_s_ready"}, 32'(bus.s_ready), 32'd0);
   endtask

   // A byte offered together with load_req must not be taken in DONE/ERR.
   task automatic pulse_load();
      @(negedge clk);
      check_output("ready_before_reload", 32'(bus.s_ready), 32'd0);
      load_req    = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hAA;
      @(posedge clk);
      @(negedge clk);
      load_req    = 1'b0;
      bus.s_valid = 1'b0;
      check_output("reload_done_low", 32'(done), 32'd0);
      check_output("reload_cpu_hold", 32'(cpu_hold), 32'd1);
      check_output("reload_err_low", 32'(err), 32'd0);
      check_output("reload_ready", 32'(bus.s_ready), 32'd1);
   endtask

   task automatic check_reset_values(input string name);
      check_output({name, "_s_ready"}, 32'(bus.s_ready), 32'd0);
      check_output({name, "_imem_we"}, 32'(bus.imem_we), 32'd0);
      check_output({name, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
      check_output({name, "_imem_wdata"}, bus.imem_wdata, 32'd0);
      check_output({name, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
      check_output({name, "_done"}, 32'(done), 32'd0);
      check_output({name, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs[6];
      logic [3:0][31:0] w;

      vecs[0].n = 2; vecs[0].gaps = 1'b0; vecs[0].words = '0;
      vecs[0].words[0] = 32'h00000013; vecs[0].words[1] = 32'h00100093;
      vecs[1] = vecs[0]; vecs[1].gaps = 1'b1;
      vecs[2].n = 0; vecs[2].gaps = 1'b0; vecs[2].words = '0;
      vecs[3].n = 1; vecs[3].gaps = 1'b0; vecs[3].words = '0;
      vecs[3].words[0] = 32'h04030201;
      vecs[4].n = 4; vecs[4].gaps = 1'b0;
      vecs[4].words[0] = 32'hDEADBEEF; vecs[4].words[1] = 32'hFFFFFFFF;
      vecs[4].words[2] = 32'h80000001; vecs[4].words[3] = 32'h00000000;
      vecs[5].n = 3; vecs[5].gaps = 1'b1; vecs[5].words = '0;
      vecs[5].words[0] = 32'h12345678; vecs[5].words[1] = 32'hA5A55A5A;
      vecs[5].words[2] = 32'h0000FF00;

      reset       = 1'b1;
      load_req    = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;
      @(negedge clk);
      check_output("idle_ready", 32'(bus.s_ready), 32'd1);
      check_output("idle_cpu_hold", 32'(cpu_hold), 32'd1);

      for (int v = 0; v < 6; v++) begin
         $display("[TB] frame %0d: n=%0d gaps=%0d", v, vecs[v].n, vecs[v].gaps);
         if (done === 1'b1) pulse_load();
         send_frame(vecs[v].n, vecs[v].words, vecs[v].gaps, 8'd0);
         check_done($sformatf("frame%0d", v));
`ifndef IMEM_LOADER_CHECKSUM_EN
         if (vecs[v].n > 0)
            check_output($sformatf("frame%0d_done_latency", v),
                         32'(done_cycle - last_we_cycle), 32'd1);
`endif
      end

      // Reset after six data bytes: only word 0 lands, then a fresh load starts at 0.
      $display("[TB] reset mid-load");
      pulse_load();
      push_write(0, 32'h11223344);
      send_byte(8'd2);
      send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
      send_byte(8'h55); send_byte(8'h66);
      @(negedge clk);
      bus.s_valid = 1'b0;
      reset       = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_values("midreset");
      check_output("midreset_pending", 32'(exp_q.size()), 32'd0);
      reset = 1'b0;
      w = '0;
      w[0] = 32'hCAFEF00D;
      send_frame(1, w, 1'b0, 8'd0);
      check_done("after_reset");

      // load_req outside DONE/ERR must not disturb a load in progress.
      $display("[TB] load_req during DATA");
      pulse_load();
      push_write(0, 32'h87654321);
      send_byte(8'd1);
      send_byte(8'h21); send_byte(8'h43);
      @(negedge clk);
      bus.s_valid = 1'b0;
      load_req    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load_req = 1'b0;
      check_output("ignored_req_ready", 32'(bus.s_ready), 32'd1);
      send_byte(8'h65); send_byte(8'h87);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h01 ^ 8'h21 ^ 8'h43 ^ 8'h65 ^ 8'h87);
`endif
      end_stream();
      check_done("ignored_req");

`ifdef IMEM_LOADER_CHECKSUM_EN
      $display("[TB] checksum mismatch");
      pulse_load();
      push_write(0, 32'h04030201);
      send_byte(8'd1);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h00);
      end_stream();
      wait_finish("bad_chk");
      check_output("bad_chk_err", 32'(err), 32'd1);
      check_output("bad_chk_cpu_hold", 32'(cpu_hold), 32'd1);
      check_output("bad_chk_done", 32'(done), 32'd0);
      check_output("bad_chk_s_ready", 32'(bus.s_ready), 32'd0);
      pulse_load();
      push_write(0, 32'h04030201);
      send_byte(8'd1);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h05);
      end_stream();
      check_done("good_chk");
`endif

      repeat (3) @(negedge clk);
      check_output("final_pending", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
